// File: rtl/rtc_clock_core_if.sv
// Register-write bus for rtc_clock_core: one field write per cycle while load
// is high. The driver of the bus uses the master modport. The clock core uses
// the slave modport.
interface rtc_clock_core_if;
  logic       load;
  logic [2:0] addrs;
  logic [5:0] data_in;

  modport master (output load, output addrs, output data_in);
  modport slave  (input  load, input  addrs, input  data_in);
endinterface

// File: rtl/rtc_clock_core.sv
// rtc_clock_core: binary time-of-day counter driven by a clk-cycle prescaler.
// It shows BCD digits in 24-hour or 12-hour form.
// Optional feature: define RTC_ALARM_EN to build the alarm registers, the
// compare logic and the latched alarm_flag. Without the macro, addrs 3/4,
// alarm_en and alarm_ack are ignored and alarm_flag is tied low.
module rtc_clock_core #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  rtc_clock_core_if.slave     bus,
  input  logic                run,
  input  logic                mode_12h,
  input  logic                alarm_en,
  input  logic                alarm_ack,
  output logic [3:0]          sec_ones,
  output logic [3:0]          sec_tens,
  output logic [3:0]          min_ones,
  output logic [3:0]          min_tens,
  output logic [3:0]          hr_ones,
  output logic [3:0]          hr_tens,
  output logic                pm,
  output logic                sec_tick,
  output logic                alarm_flag
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  // Binary 0..59 to packed BCD {tens, ones}, built from compares instead of a divider.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd50) begin
      tens = 4'd5; ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4; ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3; ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2; ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1; ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0; ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic [5:0]    sec_r;
  logic [5:0]    min_r;
  logic [4:0]    hour_r;
  logic          sec_tick_r;

  logic          tick_s;
  logic          ld_sec_s;
  logic          ld_min_s;
  logic          ld_hour_s;
  logic          time_ld_s;
  logic [5:0]    tk_sec_s;
  logic [5:0]    tk_min_s;
  logic [4:0]    tk_hour_s;
  logic          sec_carry_s;
  logic          min_carry_s;
  logic [5:0]    sec_nxt_s;
  logic [5:0]    min_nxt_s;
  logic [4:0]    hour_nxt_s;
  logic [4:0]    disp_hour_s;
  logic          pm_s;
  logic [7:0]    sec_bcd_s;
  logic [7:0]    min_bcd_s;
  logic [7:0]    hour_bcd_s;

  // The tick is the cycle in which the running prescaler wraps.
  assign tick_s    = run & (presc_r == PRESC_MAX);
  assign ld_sec_s  = bus.load & (bus.addrs == 3'd0) & (bus.data_in <= 6'd59);
  assign ld_min_s  = bus.load & (bus.addrs == 3'd1) & (bus.data_in <= 6'd59);
  assign ld_hour_s = bus.load & (bus.addrs == 3'd2) & (bus.data_in <= 6'd23);
  assign time_ld_s = ld_sec_s | ld_min_s | ld_hour_s;

  // Prescaler next value: a seconds write restarts the second; run=0 freezes it.
  always_comb begin
    presc_nxt_s = presc_r;
    if (ld_sec_s) begin
      presc_nxt_s = PRESC_ZERO;
    end else if (tick_s) begin
      presc_nxt_s = PRESC_ZERO;
    end else if (run) begin
      presc_nxt_s = presc_r + PRESC_ONE;
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Free-running seconds/minutes/hours advance with the carry chain.
  always_comb begin
    tk_sec_s    = sec_r;
    tk_min_s    = min_r;
    tk_hour_s   = hour_r;
    sec_carry_s = 1'b0;
    min_carry_s = 1'b0;
    if (tick_s) begin
      if (sec_r == 6'd59) begin
        tk_sec_s    = 6'd0;
        sec_carry_s = 1'b1;
      end else begin
        tk_sec_s    = sec_r + 6'd1;
      end
    end else begin
      tk_sec_s = sec_r;
    end
    if (sec_carry_s) begin
      if (min_r == 6'd59) begin
        tk_min_s    = 6'd0;
        min_carry_s = 1'b1;
      end else begin
        tk_min_s    = min_r + 6'd1;
      end
    end else begin
      tk_min_s = min_r;
    end
    if (min_carry_s) begin
      if (hour_r == 5'd23) begin
        tk_hour_s = 5'd0;
      end else begin
        tk_hour_s = hour_r + 5'd1;
      end
    end else begin
      tk_hour_s = hour_r;
    end
  end

  // A write overrides its field. Fields above it keep their old value, so no
  // carry leaves the written field and carries into it are dropped.
  always_comb begin
    sec_nxt_s  = tk_sec_s;
    min_nxt_s  = tk_min_s;
    hour_nxt_s = tk_hour_s;
    if (ld_sec_s) begin
      sec_nxt_s  = bus.data_in;
      min_nxt_s  = min_r;
      hour_nxt_s = hour_r;
    end else if (ld_min_s) begin
      min_nxt_s  = bus.data_in;
      hour_nxt_s = hour_r;
    end else if (ld_hour_s) begin
      hour_nxt_s = bus.data_in[4:0];
    end else begin
      sec_nxt_s  = tk_sec_s;
      min_nxt_s  = tk_min_s;
      hour_nxt_s = tk_hour_s;
    end
  end

  // Time-of-day, prescaler and seconds-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r    <= PRESC_ZERO;
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hour_r     <= 5'd0;
      sec_tick_r <= 1'b0;
    end else begin
      presc_r    <= presc_nxt_s;
      sec_r      <= sec_nxt_s;
      min_r      <= min_nxt_s;
      hour_r     <= hour_nxt_s;
      sec_tick_r <= tick_s;
    end
  end

  // Map the 0..23 hour to the displayed hour and the pm indicator.
  always_comb begin
    disp_hour_s = hour_r;
    pm_s        = 1'b0;
    if (mode_12h) begin
      pm_s = (hour_r >= 5'd12);
      if (hour_r == 5'd0) begin
        disp_hour_s = 5'd12;
      end else if (hour_r > 5'd12) begin
        disp_hour_s = hour_r - 5'd12;
      end else begin
        disp_hour_s = hour_r;
      end
    end else begin
      disp_hour_s = hour_r;
      pm_s        = 1'b0;
    end
  end

  assign sec_bcd_s  = bin_to_bcd(sec_r);
  assign min_bcd_s  = bin_to_bcd(min_r);
  assign hour_bcd_s = bin_to_bcd({1'b0, disp_hour_s});

  assign sec_tens = sec_bcd_s[7:4];
  assign sec_ones = sec_bcd_s[3:0];
  assign min_tens = min_bcd_s[7:4];
  assign min_ones = min_bcd_s[3:0];
  assign hr_tens  = hour_bcd_s[7:4];
  assign hr_ones  = hour_bcd_s[3:0];
  assign pm       = pm_s;
  assign sec_tick = sec_tick_r;

`ifdef RTC_ALARM_EN
  logic [5:0] alarm_min_r;
  logic [4:0] alarm_hour_r;
  logic       alarm_flag_r;
  logic       alarm_flag_nxt_s;
  logic       alarm_hit_s;
  logic       ld_amin_s;
  logic       ld_ahour_s;

  assign ld_amin_s  = bus.load & (bus.addrs == 3'd3) & (bus.data_in <= 6'd59);
  assign ld_ahour_s = bus.load & (bus.addrs == 3'd4) & (bus.data_in <= 6'd23);

  // Only counting can trigger the alarm. A write that lands on the alarm time does not.
  assign alarm_hit_s = alarm_en & tick_s & ~time_ld_s & (sec_nxt_s == 6'd0) &
                       (min_nxt_s == alarm_min_r) & (hour_nxt_s == alarm_hour_r);

  // Alarm time registers are loaded through the field bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_min_r  <= 6'd0;
      alarm_hour_r <= 5'd0;
    end else begin
      if (ld_amin_s) begin
        alarm_min_r <= bus.data_in;
      end else begin
        alarm_min_r <= alarm_min_r;
      end
      if (ld_ahour_s) begin
        alarm_hour_r <= bus.data_in[4:0];
      end else begin
        alarm_hour_r <= alarm_hour_r;
      end
    end
  end

  // A set has priority over an ack. Disarming also clears the flag.
  always_comb begin
    alarm_flag_nxt_s = alarm_flag_r;
    if (alarm_hit_s) begin
      alarm_flag_nxt_s = 1'b1;
    end else if (alarm_ack || !alarm_en) begin
      alarm_flag_nxt_s = 1'b0;
    end else begin
      alarm_flag_nxt_s = alarm_flag_r;
    end
  end

  // Latched alarm indication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_flag_r <= 1'b0;
    end else begin
      alarm_flag_r <= alarm_flag_nxt_s;
    end
  end

  assign alarm_flag = alarm_flag_r;
`else
  logic alarm_unused_s;
  assign alarm_unused_s = alarm_en ^ alarm_ack ^ time_ld_s;
  assign alarm_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_clock_core.sv
// Bench for rtc_clock_core with TICKS_PER_SEC=4. A total-seconds reference
// model predicts every cycle. Each prediction is queued when the stimulus is
// driven, then popped and compared after the clock edge.
module tb_rtc_clock_core;
  localparam int TPS = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic mode_12h = 1'b0;
  logic alarm_en = 1'b0;
  logic alarm_ack = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic pm, sec_tick, alarm_flag;

  rtc_clock_core_if bus ();

  rtc_clock_core #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .bus(bus), .run(run), .mode_12h(mode_12h),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .hr_ones(hr_ones), .hr_tens(hr_tens), .pm(pm), .sec_tick(sec_tick),
    .alarm_flag(alarm_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  int m_presc, m_sec, m_min, m_hr, m_amin, m_ahr;
  logic m_tick, m_flag;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] snap(input int h, input int m, input int s,
                                       input logic md, input logic tk, input logic fl);
    int dh;
    logic p;
    if (md) begin
      p  = (h >= 12);
      dh = h % 12;
      if (dh == 0) dh = 12;
    end else begin
      p  = 1'b0;
      dh = h;
    end
    return {5'd0, 4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), p, tk, fl};
  endfunction

  function automatic logic [31:0] observed();
    return {5'd0, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
            pm, sec_tick, alarm_flag};
  endfunction

  task automatic push_exp(input string tag);
    exp_q.push_back(snap(m_hr, m_min, m_sec, mode_12h, m_tick, m_flag));
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      check_eq("queue_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, observed(), e);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_sec = 0; m_min = 0; m_hr = 0; m_amin = 0; m_ahr = 0;
    m_tick = 1'b0; m_flag = 1'b0;
  endtask

  // Predict the state after the next rising edge, given the inputs now applied.
  task automatic model_edge(input int a, input int d, input logic ld, input logic ack);
    int t, nt, nh, nm, ns;
    logic tick, lsec, lmin, lhr;
    tick = run && (m_presc == TPS - 1);
    lsec = ld && (a == 0) && (d <= 59);
    lmin = ld && (a == 1) && (d <= 59);
    lhr  = ld && (a == 2) && (d <= 23);
    t  = m_hr * 3600 + m_min * 60 + m_sec;
    nt = tick ? (t + 1) % 86400 : t;
    nh = nt / 3600; nm = (nt / 60) % 60; ns = nt % 60;
    if (lsec) begin ns = d; nm = m_min; nh = m_hr; end
    else if (lmin) begin nm = d; nh = m_hr; end
    else if (lhr) nh = d;
`ifdef RTC_ALARM_EN
    if (alarm_en && tick && !(lsec || lmin || lhr) && ns == 0 && nm == m_amin && nh == m_ahr)
      m_flag = 1'b1;
    else if (ack || !alarm_en)
      m_flag = 1'b0;
    if (ld && a == 3 && d <= 59) m_amin = d;
    if (ld && a == 4 && d <= 23) m_ahr = d;
`endif
    if (lsec) m_presc = 0;
    else if (run) m_presc = tick ? 0 : m_presc + 1;
    m_sec = ns; m_min = nm; m_hr = nh; m_tick = tick;
  endtask

  // One clock cycle: drive at the falling edge, predict, sample 1 ns after the rising edge.
  task automatic step(input string tag, input logic ld, input int a, input int d, input logic ack);
    bus.load    = ld;
    bus.addrs   = 3'(a);
    bus.data_in = 6'(d);
    alarm_ack   = ack;
    model_edge(a, d, ld, ack);
    push_exp(tag);
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
    bus.load  = 1'b0;
    alarm_ack = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    step("ld_hour", 1'b1, 2, h, 1'b0);
    step("ld_min",  1'b1, 1, m, 1'b0);
    step("ld_sec",  1'b1, 0, s, 1'b0);
  endtask

  task automatic run_to_tick_cycle(input string tag);
    for (int i = 0; i < 2 * TPS && m_presc != TPS - 1; i++) step(tag, 1'b0, 0, 0, 1'b0);
    check_eq({tag, "_reach"}, 32'(m_presc), 32'(TPS - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load = 1'b0; bus.addrs = 3'd0; bus.data_in = 6'd0;
    model_reset();
    #12;
    push_exp("reset_24h"); pop_check();
    mode_12h = 1'b1; #1;
    push_exp("reset_12h"); pop_check();
    mode_12h = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Counting: a tick on every fourth cycle, 00:00:01 after the first tick.
    run = 1'b1;
    for (int i = 0; i < 9; i++) step("count", 1'b0, 0, 0, 1'b0);

    // A frozen prescaler produces no ticks.
    run = 1'b0;
    for (int i = 0; i < 6; i++) step("frozen", 1'b0, 0, 0, 1'b0);

    // Full-day wrap, shown in 12-hour mode.
    set_time(23, 59, 59);
    run = 1'b1; mode_12h = 1'b1;
    for (int i = 0; i < 5; i++) step("day_wrap", 1'b0, 0, 0, 1'b0);

    // Out-of-range writes are ignored; the 12-hour afternoon display.
    run = 1'b0;
    step("ld_h13", 1'b1, 2, 13, 1'b0);
    step("ld_sec60", 1'b1, 0, 60, 1'b0);
    step("ld_min60", 1'b1, 1, 60, 1'b0);
    step("ld_hr24", 1'b1, 2, 24, 1'b0);
    step("addr5", 1'b1, 5, 7, 1'b0);
    for (int md = 0; md < 2; md++) begin
      mode_12h = md[0];
      for (int h = 0; h < 24; h++) step("hour_disp", 1'b1, 2, h, 1'b0);
    end
    mode_12h = 1'b0;

    // A write in the tick cycle: the written field wins and drops the carry.
    set_time(5, 10, 59);
    run = 1'b1;
    run_to_tick_cycle("pre_min");
    step("ld_min_tick", 1'b1, 1, 30, 1'b0);
    run = 1'b0; set_time(8, 59, 59); run = 1'b1;
    run_to_tick_cycle("pre_hr");
    step("ld_hr_tick", 1'b1, 2, 3, 1'b0);
    run = 1'b0; set_time(9, 4, 59); run = 1'b1;
    run_to_tick_cycle("pre_sec");
    step("ld_sec_tick", 1'b1, 0, 20, 1'b0);
    for (int i = 0; i < 4; i++) step("after_sec", 1'b0, 0, 0, 1'b0);

    // Alarm at 07:00, with an ack pulse, then an ack in the set cycle.
    run = 1'b0; alarm_en = 1'b1;
    step("ld_amin", 1'b1, 3, 0, 1'b0);
    step("ld_ahr", 1'b1, 4, 7, 1'b0);
    set_time(6, 59, 59);
    run = 1'b1;
    run_to_tick_cycle("alarm_pre");
    step("alarm_set", 1'b0, 0, 0, 1'b0);
    step("alarm_hold", 1'b0, 0, 0, 1'b0);
    step("alarm_ack", 1'b0, 0, 0, 1'b1);
    step("alarm_clr", 1'b0, 0, 0, 1'b0);
    run = 1'b0; set_time(6, 59, 59); run = 1'b1;
    run_to_tick_cycle("alarm_pre2");
    step("set_wins", 1'b0, 0, 0, 1'b1);
    step("set_hold", 1'b0, 0, 0, 1'b0);
    alarm_en = 1'b0;
    step("disarm", 1'b0, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a clock phase at 12:34:56.
    run = 1'b0; set_time(12, 34, 56); run = 1'b1;
    step("pre_rst", 1'b0, 0, 0, 1'b0);
    step("pre_rst", 1'b0, 0, 0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    push_exp("async_rst"); pop_check();
    @(posedge clk); #1;
    push_exp("rst_hold"); pop_check();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step("resume", 1'b0, 0, 0, 1'b0);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
